div: RTL and testbench

Multi-cycle radix-2 restoring divider for DIV/DIVU, the producer side of the HI/LO register path. The EX stage issues operands and a start request, then stalls the pipeline until `ready_o`. The 64-bit result is presented as {remainder, quotient} so that the upper word goes to HI and the lower word goes to LO through the normal HI/LO write-back path. Division by zero completes in two cycles with an all-zero result.

---
 rtl/div.sv | 152 +++++++++++++++
 tb/tb_div.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/div.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU.
// Result is {remainder, quotient} for the HI/LO write-back path.
module div (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  localparam logic [1:0] S_FREE   = 2'b00;
  localparam logic [1:0] S_BYZERO = 2'b01;
  localparam logic [1:0] S_ON     = 2'b10;
  localparam logic [1:0] S_END    = 2'b11;

  logic [1:0]  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvsr_q, dvsr_d;
  logic        neg1_q, neg1_d;
  logic        neg2_q, neg2_d;
  logic [63:0] result_q, result_d;
  logic        ready_q, ready_d;

  logic [31:0] op1_abs;
  logic [31:0] op2_abs;
  logic        op1_neg;
  logic        op2_neg;
  logic [32:0] shifted;
  logic [33:0] diff;
  logic        borrow;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  assign op1_neg = signed_div_i & opdata1_i[31];
  assign op2_neg = signed_div_i & opdata2_i[31];
  assign op1_abs = op1_neg ? (~opdata1_i + 32'd1) : opdata1_i;
  assign op2_abs = op2_neg ? (~opdata2_i + 32'd1) : opdata2_i;

  // The shifted remainder can reach 33 bits for large divisors,
  // so the trial subtract keeps one extra bit for the borrow.
  assign shifted = {rem_q, quo_q[31]};
  assign diff    = {1'b0, shifted} - {2'b00, dvsr_q};
  assign borrow  = diff[33];

  assign quo_fix = (neg1_q ^ neg2_q) ? (~quo_q + 32'd1) : quo_q;
  assign rem_fix = neg1_q ? (~rem_q + 32'd1) : rem_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvsr_d   = dvsr_q;
    neg1_d   = neg1_q;
    neg2_d   = neg2_q;
    result_d = result_q;
    ready_d  = ready_q;
    unique case (state_q)
      S_FREE: begin
        ready_d  = 1'b0;
        result_d = 64'd0;
        if (start_i && !annul_i) begin
          if (opdata2_i == 32'd0) begin
            state_d = S_BYZERO;
          end else begin
            state_d = S_ON;
            cnt_d   = 6'd0;
            rem_d   = 32'd0;
            quo_d   = op1_abs;
            dvsr_d  = op2_abs;
            neg1_d  = op1_neg;
            neg2_d  = op2_neg;
          end
        end
      end
      S_BYZERO: begin
        if (annul_i) begin
          state_d  = S_FREE;
          ready_d  = 1'b0;
          result_d = 64'd0;
        end else begin
          state_d  = S_END;
          ready_d  = 1'b1;
          result_d = 64'd0;
        end
      end
      S_ON: begin
        if (annul_i) begin
          state_d  = S_FREE;
          ready_d  = 1'b0;
          result_d = 64'd0;
          cnt_d    = 6'd0;
        end else if (cnt_q != 6'd32) begin
          cnt_d = cnt_q + 6'd1;
          quo_d = {quo_q[30:0], ~borrow};
          rem_d = borrow ? shifted[31:0] : diff[31:0];
        end else begin
          state_d  = S_END;
          cnt_d    = 6'd0;
          ready_d  = 1'b1;
          result_d = {rem_fix, quo_fix};
        end
      end
      S_END: begin
        if (!start_i) begin
          state_d  = S_FREE;
          ready_d  = 1'b0;
          result_d = 64'd0;
        end
      end
      default: begin
        state_d  = S_FREE;
        ready_d  = 1'b0;
        result_d = 64'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FREE;
      cnt_q    <= 6'd0;
      rem_q    <= 32'd0;
      quo_q    <= 32'd0;
      dvsr_q   <= 32'd0;
      neg1_q   <= 1'b0;
      neg2_q   <= 1'b0;
      result_q <= 64'd0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvsr_q   <= dvsr_d;
      neg1_q   <= neg1_d;
      neg2_q   <= neg2_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_div.sv
// Directed bench for the restoring divider.
// Checks latency, results, hold/release, annul and reset.
module tb_div;

  logic        clk;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int total;
  int bad;

  div dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue a request, expect ready after lat edges past E0,
  // check hold while start stays high, then release.
  task automatic run_op(input string tag, input logic sgn,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input int lat);
    int cyc;
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    step();
    opdata1_i = 32'hDEAD_BEEF;
    opdata2_i = 32'h0000_0003;
    signed_div_i = ~sgn;
    cyc = 0;
    while (!ready_o && cyc < 40) begin
      step();
      cyc++;
    end
    chk({tag, "_lat"}, 64'(cyc), 64'(lat));
    chk({tag, "_res"}, result_o, exp);
    for (int i = 0; i < 2; i++) begin
      step();
      chk({tag, "_hold"}, {63'd0, ready_o}, 64'd1);
      chk({tag, "_holdres"}, result_o, exp);
    end
    start_i = 1'b0;
    step();
    chk({tag, "_rel"}, {ready_o, result_o[62:0]}, 64'd0);
    chk({tag, "_relhi"}, {63'd0, result_o[63]}, 64'd0);
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    rst          = 1'b1;
    signed_div_i = 1'b0;
    opdata1_i    = 32'd0;
    opdata2_i    = 32'd0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    step();
    step();
    chk("rst_ready", {63'd0, ready_o}, 64'd0);
    chk("rst_result", result_o, 64'd0);
    rst = 1'b0;
    step();

    run_op("u100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33);
    run_op("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2,
           {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
    run_op("s_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE,
           {32'd1, 32'hFFFF_FFFD}, 33);
    run_op("s_m100_m7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9,
           {32'hFFFF_FFFE, 32'd14}, 33);
    run_op("s_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
           {32'd0, 32'h8000_0000}, 33);
    run_op("byzero", 1'b0, 32'h1234_5678, 32'd0, 64'd0, 1);
    run_op("u_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1,
           {32'd0, 32'hFFFF_FFFF}, 33);
    run_op("u_5_9", 1'b0, 32'd5, 32'd9, {32'd5, 32'd0}, 33);
    run_op("u_max_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           {32'd0, 32'd1}, 33);
    run_op("u_big", 1'b0, 32'hF000_0000, 32'h8000_0001,
           {32'h6FFF_FFFF, 32'd1}, 33);

    // Annul sampled at E10 with start dropped: ready must never rise.
    signed_div_i = 1'b0;
    opdata1_i    = 32'd100;
    opdata2_i    = 32'd7;
    start_i      = 1'b1;
    step();
    for (int i = 0; i < 9; i++) step();
    annul_i = 1'b1;
    start_i = 1'b0;
    step();
    annul_i = 1'b0;
    chk("annul_ready", {63'd0, ready_o}, 64'd0);
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
        step();
        if (ready_o) seen = 1;
      end
      chk("annul_never", 64'(seen), 64'd0);
    end
    run_op("post_annul", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33);

    // Reset sampled at E20 while start is held.
    signed_div_i = 1'b0;
    opdata1_i    = 32'd100;
    opdata2_i    = 32'd7;
    start_i      = 1'b1;
    step();
    for (int i = 0; i < 19; i++) step();
    rst = 1'b1;
    step();
    chk("midrst_ready", {63'd0, ready_o}, 64'd0);
    chk("midrst_result", result_o, 64'd0);
    rst = 1'b0;
    step();
    begin
      int cyc;
      cyc = 0;
      while (!ready_o && cyc < 40) begin
        step();
        cyc++;
      end
      chk("rst_restart_lat", 64'(cyc), 64'd33);
      chk("rst_restart_res", result_o, {32'd2, 32'd14});
    end
    start_i = 1'b0;
    step();
    chk("final_idle", {63'd0, ready_o}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
